// File: rtl/adder_tree_pkg.sv
// Shared width arithmetic and beat classification for the pipelined adder tree.
package adder_tree_pkg;

  // How a beat leaving the last tree level acts on the output stage.
  typedef enum logic [1:0] {
    BEAT_NONE   = 2'd0,
    BEAT_SINGLE = 2'd1,
    BEAT_ACC    = 2'd2,
    BEAT_CLOSE  = 2'd3
  } beat_kind_e;

  // Operand count for a tree of the given depth.
  function automatic int unsigned n_in(input int unsigned n_stage);
    return 32'd1 << n_stage;
  endfunction

  // Width of the full tree sum.
  function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned n_stage);
    return in_w + n_stage;
  endfunction

  // Accumulator width: tree sum plus headroom.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned n_stage,
                                        input int unsigned acc_extra);
    return in_w + n_stage + acc_extra;
  endfunction

  // Width of each sum held at tree level k (level 0 is the raw operands).
  function automatic int unsigned level_w(input int unsigned in_w, input int unsigned k);
    return in_w + k;
  endfunction

  // Number of sums held at tree level k.
  function automatic int unsigned level_pairs(input int unsigned n_stage, input int unsigned k);
    return 32'd1 << (n_stage - k);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder tree level: N_PAIR pairwise sums plus valid/acc/last tags.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_PAIR = 1,
  parameter int unsigned IN_W   = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        en,
  input  logic [2*N_PAIR*IN_W-1:0]                    in_data,
  input  logic                                        in_valid,
  input  logic                                        in_acc,
  input  logic                                        in_last,
  output logic [N_PAIR*level_w(IN_W, 1)-1:0]          out_data,
  output logic                                        out_valid,
  output logic                                        out_acc,
  output logic                                        out_last
);

  localparam int unsigned OUT_W = level_w(IN_W, 1);

  logic [N_PAIR*OUT_W-1:0] sums;

  // Pair operands 2j and 2j+1 into sum j, widened by one bit so nothing is lost.
  always_comb begin
    sums = '0;
    for (int unsigned j = 0; j < N_PAIR; j++) begin
      sums[j*OUT_W +: OUT_W] = {1'b0, in_data[(2*j)*IN_W +: IN_W]}
                             + {1'b0, in_data[(2*j+1)*IN_W +: IN_W]};
    end
  end

  // Valid tag is the only state that needs reset; it advances with the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

  // Data and side tags load with the pipeline and are qualified by valid.
  always_ff @(posedge clk) begin
    if (en) begin
      out_data <= sums;
      out_acc  <= in_acc;
      out_last <= in_last;
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined unsigned adder tree with a saturating accumulator/output stage.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_STAGE   = 5,
  parameter int unsigned IN_W      = 2,
  parameter int unsigned ACC_EXTRA = 3,
  localparam int unsigned N_IN     = n_in(N_STAGE),
  localparam int unsigned SUM_W    = sum_w(IN_W, N_STAGE),
  localparam int unsigned ACC_W    = acc_w(IN_W, N_STAGE, ACC_EXTRA)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*IN_W-1:0] wx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 acc_en,
  input  logic                 in_last,
  output logic [ACC_W-1:0]     y_out,
  output logic                 sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic advance;

  // The whole pipeline moves only when the output register is free or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 1; k <= N_STAGE; k++) begin : g_lvl
    localparam int unsigned PAIRS = level_pairs(N_STAGE, k);
    localparam int unsigned W_IN  = level_w(IN_W, k - 1);

    logic [2*PAIRS*W_IN-1:0]   d_in;
    logic                      v_in;
    logic                      a_in;
    logic                      l_in;
    logic [PAIRS*(W_IN+1)-1:0] d_out;
    logic                      v_out;
    logic                      a_out;
    logic                      l_out;

    if (k == 1) begin : g_src
      assign d_in = wx;
      assign v_in = in_valid;
      assign a_in = acc_en;
      assign l_in = in_last;
    end else begin : g_src
      assign d_in = g_lvl[k-1].d_out;
      assign v_in = g_lvl[k-1].v_out;
      assign a_in = g_lvl[k-1].a_out;
      assign l_in = g_lvl[k-1].l_out;
    end

    adder_tree_level #(
      .N_PAIR (PAIRS),
      .IN_W   (W_IN)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_data   (d_in),
      .in_valid  (v_in),
      .in_acc    (a_in),
      .in_last   (l_in),
      .out_data  (d_out),
      .out_valid (v_out),
      .out_acc   (a_out),
      .out_last  (l_out)
    );
  end

  logic [SUM_W-1:0] tree_sum;
  logic             tree_valid;
  logic             tree_acc;
  logic             tree_last;

  assign tree_sum   = g_lvl[N_STAGE].d_out;
  assign tree_valid = g_lvl[N_STAGE].v_out;
  assign tree_acc   = g_lvl[N_STAGE].a_out;
  assign tree_last  = g_lvl[N_STAGE].l_out;

  logic [ACC_W-1:0] acc;
  logic             sticky;
  logic [ACC_W-1:0] ext_sum;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_carry;
  logic [ACC_W-1:0] acc_next;
  beat_kind_e       kind;

  // Classify the final-level beat and form the saturated accumulator sum.
  always_comb begin
    kind                 = BEAT_NONE;
    ext_sum              = ACC_W'(tree_sum);
    {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, ext_sum};
    acc_next             = acc_carry ? '1 : acc_sum;
    if (tree_valid) begin
      if (!tree_acc) begin
        kind = BEAT_SINGLE;
      end else if (!tree_last) begin
        kind = BEAT_ACC;
      end else begin
        kind = BEAT_CLOSE;
      end
    end
  end

  // Output register and accumulator; an independent beat leaves the accumulator alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      y_out     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      unique case (kind)
        BEAT_SINGLE: begin
          y_out     <= ext_sum;
          sat       <= 1'b0;
          out_valid <= 1'b1;
        end
        BEAT_ACC: begin
          acc       <= acc_next;
          sticky    <= sticky | acc_carry;
          out_valid <= 1'b0;
        end
        BEAT_CLOSE: begin
          y_out     <= acc_next;
          sat       <= sticky | acc_carry;
          out_valid <= 1'b1;
          acc       <= '0;
          sticky    <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 SHALL have parameter N_STAGE, default 5: tree depth; operand count N_IN = 2**N_STAGE.
REQ-002 SHALL have parameter IN_W, default 2: unsigned operand width.
REQ-003 SHALL have parameter ACC_EXTRA, default 3: accumulator headroom bits.
REQ-004 SHALL define SUM_W = IN_W+N_STAGE and ACC_W = SUM_W+ACC_EXTRA.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port wx  input  N_IN*IN_W  packed operands; operand k = wx[k*IN_W +: IN_W].
REQ-008 SHALL have port in_valid  input  1  operand vector valid.
REQ-009 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready.
REQ-010 SHALL have port acc_en  input  1  sampled with beat; 1 = accumulate across beats.
REQ-011 SHALL have port in_last  input  1  sampled with beat; closes an accumulation.
REQ-012 SHALL have port y_out  output  ACC_W  result.
REQ-013 SHALL have port sat  output  1  result saturated; qualified by out_valid.
REQ-014 SHALL have port out_valid  output  1  y_out valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts when out_valid&out_ready.

Function
REQ-016 SHALL register every tree level: level k (1..N_STAGE) holds 2**(N_STAGE-k) unsigned sums of width IN_W+k, no truncation.
REQ-017 SHALL pair operands 2j and 2j+1 of level k-1 into sum j of level k (level 0 = wx).
REQ-018 SHALL carry a valid, acc_en and last tag per level alongside data.
REQ-019 SHALL define advance = !out_valid | out_ready; all levels and output register load only when advance=1, else hold.
REQ-020 SHALL drive in_ready = advance (combinational); bubbles propagate as valid=0.
REQ-021 SHALL have latency N_STAGE+1 cycles from accepted beat to out_valid with no stall.
REQ-022 SHALL, for a level-N_STAGE beat with acc_en=0, load y_out = zero-extended sum, sat=0, out_valid=1; accumulator untouched.
REQ-023 SHALL, for acc_en=1 and last=0, add sum into accumulator, not assert out_valid for that beat.
REQ-024 SHALL, for acc_en=1 and last=1, load y_out = accumulator+sum, sat = sticky flag, out_valid=1, and clear accumulator and sticky flag same edge.
REQ-025 SHALL saturate accumulation at 2**ACC_W-1 and set sticky flag on any overflow within the accumulation.
REQ-026 SHALL drop out_valid on the accepting edge unless a new result loads the same edge (back-to-back allowed).
REQ-027 SHALL treat acc_en=0 beat mid-accumulation as independent; accumulator retained.

Reset
REQ-028 SHALL, while rst_n=0 at clk edge: clear all level valid bits, accumulator, sticky flag; y_out=0, sat=0, out_valid=0.
REQ-029 SHALL discard in-flight beats and partial accumulation on reset mid-operation; data registers need no reset beyond valids.
REQ-030 SHALL drive in_ready=1 in first cycle after reset release.

Structure
REQ-031 SHALL place width functions (SUM_W, ACC_W, level width) and N_IN derivation in shared package adder_tree_pkg.
REQ-032 SHALL implement one tree level as sub-module adder_tree_level (parameters: pair count, in width; data+tag registers, enable input), instantiated N_STAGE times via generate.
REQ-033 SHALL keep accumulator/output stage in the top module.

Verification (N_STAGE=5, IN_W=2, ACC_EXTRA=3, ACC_W=10)
REQ-034 SHALL check: single beat all operands 3, acc_en=0, out_ready=1 -> y_out=96, sat=0, out_valid exactly 6 cycles after accept.
REQ-035 SHALL check: 4 beats all-3, acc_en=1, in_last on 4th -> one out_valid, y_out=384, sat=0; accumulator then 0.
REQ-036 SHALL check: 11 beats all-3 accumulated, last on 11th -> y_out=1023, sat=1; next acc_en=0 beat of all-1 -> y_out=32, sat=0.
REQ-037 SHALL check: continuous in_valid, out_ready low 3 cycles while out_valid -> y_out held, in_ready=0, no beat lost/duplicated; stream of ramp vectors matches model in order.
REQ-038 SHALL check: rst_n low 1 cycle with 3 beats in flight and partial accumulation -> out_valid=0 next cycle, no stale result emerges, fresh 1-beat accumulation with last gives its own sum only.
